// File: rtl/serial_ripple_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, BITS_PER_CYCLE bits per clock.
// Define SERIAL_SUB_CMP_FLAGS_EN to add the lt_u / lt_s / eq comparison outputs.
module serial_ripple_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
`ifdef SERIAL_SUB_CMP_FLAGS_EN
  output logic             lt_u,
  output logic             lt_s,
  output logic             eq,
`endif
  output logic             zero
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                r_state;
  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic [WIDTH-1:0]          r_acc;
  logic                      r_borrow;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_a_msb;
  logic                      r_b_msb;
  logic [WIDTH-1:0]          r_diff;
  logic                      r_borrow_out;
  logic                      r_overflow;
  logic                      r_zero;
`ifdef SERIAL_SUB_CMP_FLAGS_EN
  logic                      r_lt_u;
  logic                      r_lt_s;
  logic                      r_eq;
`endif

  logic [BITS_PER_CYCLE-1:0] w_slice;
  logic                      w_borrow_next;
  logic [WIDTH-1:0]          w_acc_next;
  logic                      w_last_step;
  logic                      w_ovf_next;

  // Full-subtractor chain over the low slice of the operand shift registers
  always_comb begin
    logic x;
    logic y;
    logic bq;
    bq      = r_borrow;
    w_slice = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      x          = r_a[i];
      y          = r_b[i];
      w_slice[i] = x ^ y ^ bq;
      bq         = (~x & y) | (~(x ^ y) & bq);
    end
    w_borrow_next = bq;
  end

  // Result fills from the MSB side so the first slice ends up in the LSBs
  assign w_acc_next  = (r_acc >> BITS_PER_CYCLE) |
                       (WIDTH'(w_slice) << (WIDTH - BITS_PER_CYCLE));
  assign w_last_step = (r_state == RUN) && (r_cnt == CNT_W'(N - 1));
  assign w_ovf_next  = (r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
`ifdef SERIAL_SUB_CMP_FLAGS_EN
      r_lt_u       <= 1'b0;
      r_lt_s       <= 1'b0;
      r_eq         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> BITS_PER_CYCLE;
          r_b      <= r_b >> BITS_PER_CYCLE;
          r_acc    <= w_acc_next;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last_step) begin
            r_diff       <= w_acc_next;
            r_borrow_out <= w_borrow_next;
            r_overflow   <= w_ovf_next;
            r_zero       <= (w_acc_next == '0);
`ifdef SERIAL_SUB_CMP_FLAGS_EN
            r_lt_u       <= w_borrow_next;
            r_lt_s       <= w_acc_next[WIDTH-1] ^ w_ovf_next;
            r_eq         <= (w_acc_next == '0);
`endif
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign overflow   = r_overflow;
  assign zero       = r_zero;
`ifdef SERIAL_SUB_CMP_FLAGS_EN
  assign lt_u       = r_lt_u;
  assign lt_s       = r_lt_s;
  assign eq         = r_eq;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: instance 0 is bit-serial (8 steps), instance 1 uses 4-bit slices (2 steps).
module tb_serial_ripple_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] a         [2];
  logic [7:0] b         [2];
  logic       bin       [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] diff      [2];
  logic       borrow_out[2];
  logic       overflow  [2];
  logic       zero      [2];
`ifdef SERIAL_SUB_CMP_FLAGS_EN
  logic       lt_u      [2];
  logic       lt_s      [2];
  logic       eq        [2];
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t q0[$];
  vec_t q1[$];
  vec_t tbl[8];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    serial_ripple_subtractor #(
      .WIDTH         (8),
      .BITS_PER_CYCLE((g == 0) ? 1 : 4)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .bin       (bin[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .diff      (diff[g]),
      .borrow_out(borrow_out[g]),
      .overflow  (overflow[g]),
`ifdef SERIAL_SUB_CMP_FLAGS_EN
      .lt_u      (lt_u[g]),
      .lt_s      (lt_s[g]),
      .eq        (eq[g]),
`endif
      .zero      (zero[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t model(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    vec_t       v;
    logic [8:0] f;
    f     = {1'b0, ia} - {1'b0, ib} - {8'd0, ibin};
    v.a   = ia;
    v.b   = ib;
    v.bin = ibin;
    v.d   = f[7:0];
    v.bo  = f[8];
    v.ov  = (ia[7] != ib[7]) && (f[7] != ia[7]);
    v.z   = (f[7:0] == 8'd0);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted, then scramble the inputs and queue the expectation
  task automatic send(input int s, input vec_t e);
    logic rdy;
    int   k;
    in_valid[s] = 1'b1;
    a[s]        = e.a;
    b[s]        = e.b;
    bin[s]      = e.bin;
    k           = 0;
    do begin
      rdy = in_ready[s];
      tick();
      k++;
    end while (!rdy && k < 50);
    in_valid[s] = 1'b0;
    a[s]        = 8'($urandom);
    b[s]        = 8'($urandom);
    bin[s]      = 1'($urandom);
    if (!rdy) check("accept_timeout", 0, 1);
    else if (s == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_and_check(input int s, input int lat);
    vec_t e;
    int   k;
    k = 0;
    while (!out_valid[s] && k < 50) begin
      tick();
      k++;
    end
    check("latency", k, lat);
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = (s == 0) ? q0.pop_front() : q1.pop_front();
      check("diff", diff[s], e.d);
      check("borrow_out", borrow_out[s], e.bo);
      check("overflow", overflow[s], e.ov);
      check("zero", zero[s], e.z);
      check("in_ready_done", in_ready[s], 0);
`ifdef SERIAL_SUB_CMP_FLAGS_EN
      check("lt_u", lt_u[s], e.bo);
      check("lt_s", lt_s[s], e.d[7] ^ e.ov);
      check("eq", eq[s], e.z);
`endif
    end
  endtask

  task automatic handshake(input int s);
    out_ready[s] = 1'b1;
    tick();
    out_ready[s] = 1'b0;
    check("out_valid_after_hs", out_valid[s], 0);
    check("in_ready_after_hs", in_ready[s], 1);
  endtask

  initial begin
    vec_t e;
    tbl[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b0;
      a[s]         = 8'h00;
      b[s]         = 8'h00;
      bin[s]       = 1'b0;
    end
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready", in_ready[s], 1);
      check("rst_out_valid", out_valid[s], 0);
      check("rst_diff", diff[s], 0);
      check("rst_flags", {borrow_out[s], overflow[s], zero[s]}, 0);
    end
    rst_n = 1'b1;

    // Directed vectors on the bit-serial instance
    for (int i = 0; i < 7; i++) begin
      send(0, tbl[i]);
      wait_and_check(0, 8);
      handshake(0);
    end

    // Backpressure: result held, new operands refused until the handshake clears
    send(0, model(8'h44, 8'h11, 1'b0));
    wait_and_check(0, 8);
    in_valid[0] = 1'b1;
    a[0]        = 8'hAA;
    b[0]        = 8'h0B;
    bin[0]      = 1'b0;
    repeat (5) begin
      tick();
      check("bp_diff_held", diff[0], 8'h33);
      check("bp_out_valid", out_valid[0], 1);
      check("bp_in_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("bp_release_valid", out_valid[0], 0);
    check("bp_release_ready", in_ready[0], 1);
    tick();
    check("bp_pending_accepted", in_ready[0], 0);
    in_valid[0] = 1'b0;
    q0.push_back(model(8'hAA, 8'h0B, 1'b0));
    wait_and_check(0, 8);
    handshake(0);

    // Reset three cycles into an operation
    send(0, tbl[0]);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid[0], 0);
    check("midrst_in_ready", in_ready[0], 1);
    check("midrst_diff", diff[0], 0);
    check("midrst_flags", {borrow_out[0], overflow[0], zero[0]}, 0);
    q0.delete();
    tick();
    rst_n = 1'b1;
    send(0, tbl[7]);
    wait_and_check(0, 8);
    handshake(0);

    // Four bits per step
    send(1, tbl[1]);
    wait_and_check(1, 2);
    handshake(1);
    for (int i = 0; i < 20; i++) begin
      e = model(8'($urandom), 8'($urandom), 1'($urandom));
      send(1, e);
      wait_and_check(1, 2);
      handshake(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
